// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU AXI-lite initiator: access types, FSM states
// and the single-bit response encoding used on rresp/bresp.
package lsu_pkg;

  localparam logic [2:0] MT_B  = 3'd0;
  localparam logic [2:0] MT_H  = 3'd1;
  localparam logic [2:0] MT_W  = 3'd2;
  localparam logic [2:0] MT_BU = 3'd3;
  localparam logic [2:0] MT_HU = 3'd4;

  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERR  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_AW_W,
    S_WR_RESP,
    S_RESP
  } state_t;

  // Access width code: 0 = byte, 1 = half, 2 = word (illegal codes map to word)
  function automatic logic [1:0] access_size(input logic [2:0] mtype);
    case (mtype)
      MT_B, MT_BU: access_size = 2'd0;
      MT_H, MT_HU: access_size = 2'd1;
      default:     access_size = 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for a 32-bit bus: store data/strobe placement, load
// extraction with sign/zero extension, and alignment/type legality.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic        wen,
  input  logic [1:0]  offset,
  input  logic [2:0]  mtype,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] load_data,
  output logic        illegal
);

  logic [1:0]  size;
  logic [31:0] shifted;

  always_comb begin
    size    = access_size(mtype);
    wdata   = store_data << {offset, 3'b000};
    shifted = load_word >> {offset, 3'b000};

    case (size)
      2'd0:    wstrb = 4'b0001 << offset;
      2'd1:    wstrb = 4'b0011 << offset;
      default: wstrb = 4'b1111 << offset;
    endcase

    case (mtype)
      MT_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      MT_BU:   load_data = {24'd0, shifted[7:0]};
      MT_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      MT_HU:   load_data = {16'd0, shifted[15:0]};
      default: load_data = load_word;
    endcase

    // Store types stop at sw; load types stop at lhu
    illegal = wen ? (mtype > MT_W) : (mtype > MT_HU);
    if (size == 2'd1 && offset[0]) illegal = 1'b1;
    if (size == 2'd2 && offset != 2'd0) illegal = 1'b1;
  end

endmodule

// File: rtl/lsu_axi_master.sv
// Single-outstanding AXI-lite initiator for the LSU: one request in, one bus
// transaction (or an immediate error for illegal requests), one response out.
module lsu_axi_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [2:0]        req_mtype,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic              bresp,
  input  logic              bvalid,
  output logic              bready
);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        mtype_q;
  logic              idle;
  logic [1:0]        al_offset;
  logic [2:0]        al_mtype;
  logic [31:0]       al_wdata;
  logic [3:0]        al_wstrb;
  logic [31:0]       al_load;
  logic              al_illegal;
  logic              aw_done;
  logic              w_done;

  // The aligner sees the live request while idle and the latched one afterwards
  assign idle      = (state == S_IDLE);
  assign req_ready = idle;
  assign al_offset = idle ? req_addr[1:0] : addr_q[1:0];
  assign al_mtype  = idle ? req_mtype : mtype_q;
  assign araddr    = addr_q;
  assign awaddr    = addr_q;
  assign aw_done   = !awvalid || awready;
  assign w_done    = !wvalid || wready;

  lsu_lane_align u_align (
    .wen        (req_wen),
    .offset     (al_offset),
    .mtype      (al_mtype),
    .store_data (req_wdata),
    .load_word  (rdata),
    .wdata      (al_wdata),
    .wstrb      (al_wstrb),
    .load_data  (al_load),
    .illegal    (al_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      mtype_q    <= '0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      wdata      <= '0;
      wstrb      <= '0;
      bready     <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_q     <= req_addr;
            mtype_q    <= req_mtype;
            resp_rdata <= '0;
            resp_err   <= RESP_OKAY;
            if (al_illegal) begin
              resp_err   <= RESP_ERR;
              resp_valid <= 1'b1;
              state      <= S_RESP;
            end else if (req_wen) begin
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              wdata   <= al_wdata;
              wstrb   <= al_wstrb;
              state   <= S_WR_AW_W;
            end else begin
              arvalid <= 1'b1;
              state   <= S_RD_ADDR;
            end
          end
        end
        S_RD_ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (rvalid) begin
            rready     <= 1'b0;
            resp_rdata <= al_load;
            resp_err   <= rresp;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end
        end
        // AW and W retire independently; move on once neither is still pending
        S_WR_AW_W: begin
          if (awready) awvalid <= 1'b0;
          if (wready) wvalid <= 1'b0;
          if (aw_done && w_done) begin
            bready <= 1'b1;
            state  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (bvalid) begin
            bready     <= 1'b0;
            resp_err   <= bresp;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_axi_master.sv
// Bench for lsu_axi_master: delayed SRAM responder, reference memory model and
// a response scoreboard, driven by directed steps followed by a random mix.
module tb_lsu_axi_master;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_mtype;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rresp, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bresp, bvalid, bready;
  logic [3:0]  wstrb;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem[16];
  logic [31:0] ref_mem[16];
  int          checks = 0;
  int          errors = 0;
  int          ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
  bit          rand_delays = 0;
  bit          err_next_read = 0;
  bit          spurious = 0;
  int          bus_cycles = 0;

  always #5 clk = ~clk;

  lsu_axi_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_mtype(req_mtype),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  function automatic void check_output(input string tag, input logic [31:0] observed,
                                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endfunction

  // Reference model: legality, load extension and store merge into ref_mem
  function automatic exp_t model(input logic wen, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [2:0] mt, input logic inj);
    exp_t        e;
    logic        bad;
    int          sh, nb;
    logic [3:0]  idx;
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    sh  = int'(addr[1:0]);
    idx = addr[5:2];
    bad = wen ? (mt > 3'd2) : (mt > 3'd4);
    if ((mt == 3'd1 || mt == 3'd4) && addr[0]) bad = 1'b1;
    if (mt == 3'd2 && addr[1:0] != 2'd0) bad = 1'b1;
    e.rdata = 32'd0;
    e.err   = bad;
    if (!bad) begin
      w = ref_mem[idx];
      if (wen) begin
        nb = (mt == 3'd0) ? 1 : (mt == 3'd1) ? 2 : 4;
        for (int k = 0; k < nb; k++) w[8*(sh+k) +: 8] = wd[8*k +: 8];
        ref_mem[idx] = w;
      end else begin
        b = w[8*sh +: 8];
        h = (sh >= 2) ? w[31:16] : w[15:0];
        case (mt)
          3'd0:    e.rdata = {{24{b[7]}}, b};
          3'd3:    e.rdata = {24'd0, b};
          3'd1:    e.rdata = {{16{h[15]}}, h};
          3'd4:    e.rdata = {16'd0, h};
          default: e.rdata = w;
        endcase
        e.err = inj;
      end
    end
    return e;
  endfunction

  // Delayed SRAM responder; handshakes are sampled at negedge, drives at posedge+1
  initial begin
    bit          ar_hs, r_hs, aw_hs, w_hs, b_hs, ar_w, aw_w, w_w, rst_seen;
    bit          r_pend, b_pend, have_aw, have_w, r_err;
    int          ar_cnt, aw_cnt, w_cnt, r_wait, b_wait;
    logic [31:0] hs_araddr, hs_awaddr, hs_wdata, r_addr, w_addr, w_data;
    logic [3:0]  hs_wstrb, w_strb;
    {r_pend, b_pend, have_aw, have_w, r_err} = '0;
    {ar_cnt, aw_cnt, w_cnt, r_wait, b_wait} = '0;
    r_addr = 0; w_addr = 0; w_data = 0; w_strb = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    forever begin
      @(negedge clk);
      ar_hs = arvalid && arready;  ar_w = arvalid && !arready;
      aw_hs = awvalid && awready;  aw_w = awvalid && !awready;
      w_hs  = wvalid && wready;    w_w  = wvalid && !wready;
      r_hs  = rvalid && rready;    b_hs = bvalid && bready;
      rst_seen = rst;
      if (arvalid || awvalid || wvalid) bus_cycles++;
      hs_araddr = araddr; hs_awaddr = awaddr; hs_wdata = wdata; hs_wstrb = wstrb;
      @(posedge clk);
      #1;
      if (rst_seen) begin
        {r_pend, b_pend, have_aw, have_w} = '0;
        {ar_cnt, aw_cnt, w_cnt, r_wait, b_wait} = '0;
      end else begin
        if (ar_hs) ar_cnt = 0; else if (ar_w) ar_cnt++;
        if (aw_hs) aw_cnt = 0; else if (aw_w) aw_cnt++;
        if (w_hs) w_cnt = 0; else if (w_w) w_cnt++;
        if (r_hs) r_pend = 0; else if (r_pend && r_wait > 0) r_wait--;
        if (b_hs) b_pend = 0; else if (b_pend && b_wait > 0) b_wait--;
        if (ar_hs) begin
          r_pend = 1; r_addr = hs_araddr; r_err = err_next_read; err_next_read = 0;
          r_wait = rand_delays ? int'($urandom_range(0, 3)) : r_delay;
        end
        if (aw_hs) begin have_aw = 1; w_addr = hs_awaddr; end
        if (w_hs) begin have_w = 1; w_data = hs_wdata; w_strb = hs_wstrb; end
        if (have_aw && have_w && !b_pend) begin
          for (int k = 0; k < 4; k++)
            if (w_strb[k]) mem[w_addr[5:2]][8*k +: 8] = w_data[8*k +: 8];
          b_pend = 1; have_aw = 0; have_w = 0;
          b_wait = rand_delays ? int'($urandom_range(0, 3)) : b_delay;
        end
      end
      arready = arvalid && (rand_delays ? ($urandom_range(0, 1) == 1) : (ar_cnt >= ar_delay));
      awready = awvalid && (rand_delays ? ($urandom_range(0, 1) == 1) : (aw_cnt >= aw_delay));
      wready  = wvalid && (rand_delays ? ($urandom_range(0, 1) == 1) : (w_cnt >= w_delay));
      rvalid  = (r_pend && r_wait == 0) || spurious;
      rdata   = mem[r_addr[5:2]];
      rresp   = r_pend && r_err;
      bvalid  = b_pend && b_wait == 0;
      bresp   = 1'b0;
    end
  end

  // Payload and valid must hold while a channel is stalled
  initial begin
    logic        p_ar, p_aw, p_w;
    logic [31:0] p_araddr, p_awaddr, p_wdata;
    logic [3:0]  p_wstrb;
    p_ar = 0; p_aw = 0; p_w = 0;
    p_araddr = 0; p_awaddr = 0; p_wdata = 0; p_wstrb = 0;
    forever begin
      @(negedge clk);
      if (p_ar) begin
        check_output("ar_hold_valid", arvalid, 1);
        check_output("ar_hold_addr", araddr, p_araddr);
      end
      if (p_aw) begin
        check_output("aw_hold_valid", awvalid, 1);
        check_output("aw_hold_addr", awaddr, p_awaddr);
      end
      if (p_w) begin
        check_output("w_hold_valid", wvalid, 1);
        check_output("w_hold_data", wdata, p_wdata);
        check_output("w_hold_strb", wstrb, p_wstrb);
      end
      p_ar = arvalid && !arready && !rst;
      p_aw = awvalid && !awready && !rst;
      p_w  = wvalid && !wready && !rst;
      p_araddr = araddr; p_awaddr = awaddr; p_wdata = wdata; p_wstrb = wstrb;
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request, push its expected response and wait for the accept edge
  task automatic apply_stimulus(input logic wen, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [2:0] mt);
    int guard = 0;
    sb.push_back(model(wen, addr, wd, mt, err_next_read && !wen));
    req_valid = 1; req_wen = wen; req_addr = addr; req_wdata = wd; req_mtype = mt;
    while (!req_ready && guard < 50) begin tick(); guard++; end
    check_output("accept", 32'(guard < 50), 1);
    tick();
    req_valid = 0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 60) begin tick(); lat++; end
  endtask

  // Compare the response against the scoreboard, stall it for hold cycles, retire it
  task automatic check_output_resp(input int hold);
    exp_t e;
    check_output("resp_valid", resp_valid, 1);
    if (sb.size() == 0) begin
      e.rdata = 32'hxxxx_xxxx; e.err = 1'bx;
    end else e = sb.pop_front();
    check_output("resp_rdata", resp_rdata, e.rdata);
    check_output("resp_err", resp_err, e.err);
    if (hold > 0) begin
      repeat (hold) tick();
      check_output("resp_hold_valid", resp_valid, 1);
      check_output("resp_hold_rdata", resp_rdata, e.rdata);
    end
    resp_ready = 1;
    tick();
    resp_ready = 0;
    check_output("resp_retired", resp_valid, 0);
    check_output("idle_after_resp", req_ready, 1);
  endtask

  initial begin
    int          lat, snap;
    logic        wen;
    logic [2:0]  mt;
    logic [1:0]  off;
    logic [3:0]  idx;
    rst = 1; req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0; req_mtype = 0;
    resp_ready = 0;
    for (int i = 0; i < 16; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
    repeat (3) tick();
    check_output("rst_arvalid", arvalid, 0);
    check_output("rst_awvalid", awvalid, 0);
    check_output("rst_wvalid", wvalid, 0);
    check_output("rst_rready", rready, 0);
    check_output("rst_bready", bready, 0);
    check_output("rst_resp_valid", resp_valid, 0);
    check_output("rst_resp_rdata", resp_rdata, 0);
    check_output("rst_resp_err", resp_err, 0);
    rst = 0;
    tick();
    check_output("rst_req_ready", req_ready, 1);

    $display("[TB] lw with immediate responder");
    mem[1] = 32'hDEAD_BEEF; ref_mem[1] = 32'hDEAD_BEEF;
    apply_stimulus(0, 32'h8000_0004, 0, MT_W);
    check_output("lw_arvalid", arvalid, 1);
    check_output("lw_araddr", araddr, 32'h8000_0004);
    wait_resp(lat);
    check_output("lw_latency", lat, 3);
    check_output_resp(2);

    $display("[TB] byte/half extension");
    mem[2] = 32'h80FF_1234; ref_mem[2] = 32'h80FF_1234;
    apply_stimulus(0, 32'h8000_000B, 0, MT_B);  wait_resp(lat); check_output_resp(0);
    apply_stimulus(0, 32'h8000_000B, 0, MT_BU); wait_resp(lat); check_output_resp(0);
    apply_stimulus(0, 32'h8000_000A, 0, MT_HU); wait_resp(lat); check_output_resp(1);
    apply_stimulus(0, 32'h8000_000A, 0, MT_H);  wait_resp(lat); check_output_resp(0);

    $display("[TB] sh with AW ahead of W");
    w_delay = 3;
    apply_stimulus(1, 32'h8000_0006, 32'h0000_ABCD, MT_H);
    check_output("sh_awvalid", awvalid, 1);
    check_output("sh_wvalid", wvalid, 1);
    check_output("sh_wdata", wdata, 32'hABCD_0000);
    check_output("sh_wstrb", wstrb, 4'b1100);
    tick();
    check_output("sh_aw_retired", awvalid, 0);
    check_output("sh_w_pending", wvalid, 1);
    wait_resp(lat);
    check_output_resp(0);
    tick();
    check_output("sh_single_resp", resp_valid, 0);
    w_delay = 0;
    apply_stimulus(0, 32'h8000_0004, 0, MT_W); wait_resp(lat); check_output_resp(0);

    $display("[TB] misaligned requests");
    snap = bus_cycles;
    apply_stimulus(0, 32'h8000_0002, 0, MT_W);
    wait_resp(lat);
    check_output("lw_misaligned_latency", lat, 1);
    check_output_resp(0);
    apply_stimulus(1, 32'h8000_0001, 32'h1234_5678, MT_H);
    wait_resp(lat);
    check_output("sh_misaligned_latency", lat, 1);
    check_output_resp(0);
    tick();
    check_output("misaligned_no_bus", bus_cycles, snap);

    $display("[TB] unexpected rvalid while idle");
    spurious = 1;
    repeat (3) tick();
    check_output("spurious_rready", rready, 0);
    check_output("spurious_resp_valid", resp_valid, 0);
    check_output("spurious_req_ready", req_ready, 1);
    spurious = 0;
    tick();

    $display("[TB] reset during pending AR");
    ar_delay = 20;
    apply_stimulus(0, 32'h8000_0010, 0, MT_W);
    repeat (3) tick();
    check_output("mid_arvalid", arvalid, 1);
    rst = 1;
    tick();
    rst = 0;
    sb.delete();
    check_output("mid_rst_arvalid", arvalid, 0);
    check_output("mid_rst_rready", rready, 0);
    check_output("mid_rst_resp_valid", resp_valid, 0);
    check_output("mid_rst_req_ready", req_ready, 1);
    ar_delay = 0;
    tick();
    apply_stimulus(0, 32'h8000_0010, 0, MT_W); wait_resp(lat); check_output_resp(0);

    $display("[TB] random mixed traffic");
    rand_delays = 1;
    for (int i = 0; i < 1000 && errors < 20; i++) begin
      wen = (i == 500) ? 1'b0 : 1'($urandom_range(0, 1));
      mt  = wen ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 4));
      case (access_size(mt))
        2'd0:    off = 2'($urandom_range(0, 3));
        2'd1:    off = {1'($urandom_range(0, 1)), 1'b0};
        default: off = 2'd0;
      endcase
      if ($urandom_range(0, 15) == 0) begin
        mt = 3'($urandom_range(0, 7)); off = 2'($urandom_range(0, 3));
      end
      if (i == 500) begin mt = MT_W; off = 2'd0; err_next_read = 1; end
      idx = 4'($urandom_range(0, 15));
      apply_stimulus(wen, 32'h8000_0000 | (32'(idx) << 2) | 32'(off), $urandom, mt);
      wait_resp(lat);
      check_output_resp(int'($urandom_range(0, 2)));
    end
    rand_delays = 0;
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
